// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter engine and its coefficient controller.
//   - default tap count and coefficient width
//   - coefficient index width helper and index/coefficient typedefs
//   - identity tap value (largest positive Q1.(BITWIDTH-1) number, ~1.0)
//   - load FSM state enum
package fir_pkg;

    localparam int COEFF_LENGTH_DEF = 23;
    localparam int BITWIDTH_DEF     = 24;

    // Index width for n taps; at least one bit, so a single-tap build still works.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic        [idx_width(COEFF_LENGTH_DEF)-1:0] coeff_idx_t;
    typedef logic signed [BITWIDTH_DEF-1:0]                 coeff_t;

    localparam coeff_t IDENTITY_TAP = coeff_t'((64'd1 << (BITWIDTH_DEF - 1)) - 64'd1);

    typedef enum logic {
        LOAD_FILL    = 1'b0,
        LOAD_PENDING = 1'b1
    } load_state_e;

endpackage

// File: rtl/fir_coeff_controller_if.sv
// Coefficient write channel between the host register block and the
// controller.
//   wr_valid   : host offers a coefficient
//   wr_ready   : controller accepts it (high while the shadow bank is filling)
//   wr_data    : signed coefficient, index implied by arrival order
//   load_abort : discard a partially loaded shadow bank
// master = host side, slave = controller side.
interface fir_coeff_controller_if #(
    parameter int BITWIDTH = 24
);
    logic                wr_valid;
    logic                wr_ready;
    logic [BITWIDTH-1:0] wr_data;
    logic                load_abort;

    modport master (output wr_valid, output wr_data, output load_abort, input wr_ready);
    modport slave  (input wr_valid, input wr_data, input load_abort, output wr_ready);
endinterface

// File: rtl/fir_coeff_controller.sv
// Sequencing and coefficient controller for the single-channel FIR engine.
// Forwards sample ticks to the filter, tracks whether a filter run is in
// flight, and double-buffers the coefficient set: a new set streams into a
// shadow bank and is copied into the active bank only while no run is in
// flight, so a run never sees mixed coefficients.
//
// Ports:
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   sample_tick_i  one-cycle pulse per input sample
//   fir_tick_o     registered start pulse to the filter
//   fir_done_i     filter run finished
//   coeff_o        active coefficient bank, tap k in coeff_o[k] (two's complement)
//   wr             coefficient write channel (slave side)
//   swapped_o      one-cycle pulse when the shadow bank is committed
//   pending_o      full shadow bank waiting for commit
//   overrun_o      sticky: a sample tick was dropped because the engine was busy
//   overrun_clr_i  clears overrun_o
module fir_coeff_controller
    import fir_pkg::*;
#(
    parameter int COEFF_LENGTH = COEFF_LENGTH_DEF,
    parameter int BITWIDTH     = BITWIDTH_DEF
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   sample_tick_i,
    output logic                                   fir_tick_o,
    input  logic                                   fir_done_i,
    output logic [COEFF_LENGTH-1:0][BITWIDTH-1:0]  coeff_o,
    fir_coeff_controller_if.slave                  wr,
    output logic                                   swapped_o,
    output logic                                   pending_o,
    output logic                                   overrun_o,
    input  logic                                   overrun_clr_i
);

    localparam int                  IDX_W    = idx_width(COEFF_LENGTH);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(COEFF_LENGTH - 1);
    localparam logic [BITWIDTH-1:0] ID_TAP   = {1'b0, {(BITWIDTH-1){1'b1}}};

    load_state_e                          state_q, state_d;
    logic [IDX_W-1:0]                     idx_q, idx_d;
    logic                                 busy_q, busy_d;
    logic                                 fir_tick_q, fir_tick_d;
    logic                                 swapped_q, swapped_d;
    logic                                 overrun_q, overrun_d;
    logic [BITWIDTH-1:0]                  shadow_q [COEFF_LENGTH];
    logic [COEFF_LENGTH-1:0][BITWIDTH-1:0] active_q;

    logic wr_accept;
    logic commit;
    logic tick_fwd;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wr_accept = 1'b0;
        commit    = 1'b0;

        case (state_q)
            LOAD_FILL: begin
                // Abort has priority over a coincident write, which is dropped.
                if (wr.load_abort) begin
                    idx_d = '0;
                end else if (wr.wr_valid) begin
                    wr_accept = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = LOAD_PENDING;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            LOAD_PENDING: begin
                // A tick already issued counts as in flight even before busy
                // rises, so the bank must not change under it.
                if (!busy_q && !fir_tick_q) begin
                    commit  = 1'b1;
                    state_d = LOAD_FILL;
                end
            end
            default: state_d = LOAD_FILL;
        endcase

        // A done in the same cycle frees the engine for this tick.
        tick_fwd   = sample_tick_i && !fir_tick_q && (!busy_q || fir_done_i);
        fir_tick_d = tick_fwd;
        swapped_d  = commit;
        // Start of a new run outranks completion of the previous one.
        busy_d     = fir_tick_q || (busy_q && !fir_done_i);
        // A fresh overrun outranks a clear in the same cycle.
        overrun_d  = (sample_tick_i && !tick_fwd) || (overrun_q && !overrun_clr_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= LOAD_FILL;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            fir_tick_q <= 1'b0;
            swapped_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            fir_tick_q <= fir_tick_d;
            swapped_q  <= swapped_d;
            overrun_q  <= overrun_d;
        end
    end

    // One register per tap: the shadow entry loads when its index is written,
    // the active entry loads from the shadow on commit.
    for (genvar gi = 0; gi < COEFF_LENGTH; gi++) begin : g_tap
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                shadow_q[gi] <= '0;
            end else if (wr_accept && (idx_q == IDX_W'(gi))) begin
                shadow_q[gi] <= wr.wr_data;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                active_q[gi] <= (gi == 0) ? ID_TAP : '0;
            end else if (commit) begin
                active_q[gi] <= shadow_q[gi];
            end
        end
    end

    assign fir_tick_o  = fir_tick_q;
    assign swapped_o   = swapped_q;
    assign overrun_o   = overrun_q;
    assign pending_o   = (state_q == LOAD_PENDING);
    assign wr.wr_ready = (state_q == LOAD_FILL);
    assign coeff_o     = active_q;

endmodule

// File: tb/tb_fir_coeff_controller.sv
// Bench for fir_coeff_controller: directed scenarios, a queue-based reference
// model checked every cycle, a filter stand-in that raises done 24 cycles
// after each tick, and literal checks at key points.
module tb_fir_coeff_controller;
    import fir_pkg::*;

    localparam int N = COEFF_LENGTH_DEF;
    localparam int W = BITWIDTH_DEF;
    localparam int RUN_CYCLES = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sample_tick = 1'b0;
    logic overrun_clr = 1'b0;
    logic fir_tick, fir_done, swapped, pending, overrun;
    logic [N-1:0][W-1:0] coeff;

    fir_coeff_controller_if #(.BITWIDTH(W)) wr_if ();

    always #5 clk = ~clk;

    fir_coeff_controller #(.COEFF_LENGTH(N), .BITWIDTH(W)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .sample_tick_i (sample_tick),
        .fir_tick_o    (fir_tick),
        .fir_done_i    (fir_done),
        .coeff_o       (coeff),
        .wr            (wr_if),
        .swapped_o     (swapped),
        .pending_o     (pending),
        .overrun_o     (overrun),
        .overrun_clr_i (overrun_clr)
    );

    // Filter stand-in: a run lasts RUN_CYCLES cycles from the tick.
    int run_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)              run_cnt <= 0;
        else if (fir_tick)       run_cnt <= RUN_CYCLES;
        else if (run_cnt != 0)   run_cnt <= run_cnt - 1;
    end
    assign fir_done = (run_cnt == 1);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: words collect in a queue; a full queue waits until the
    // engine is idle and then becomes the active bank.
    logic [W-1:0] m_active [N];
    logic [W-1:0] m_q [$];
    bit m_pending, m_running, m_tick, m_swapped, m_overrun;

    always @(posedge clk or negedge rst_n) begin : model
        bit fwd;
        bit do_commit;
        if (!rst_n) begin
            m_q.delete();
            m_pending = 0; m_running = 0; m_tick = 0; m_swapped = 0; m_overrun = 0;
            for (int k = 0; k < N; k++) m_active[k] = (k == 0) ? IDENTITY_TAP : '0;
        end else begin
            do_commit = m_pending && !m_running && !m_tick;
            fwd = sample_tick && !m_tick && (!m_running || fir_done);
            if (!m_pending) begin
                if (wr_if.load_abort) m_q.delete();
                else if (wr_if.wr_valid) begin
                    m_q.push_back(wr_if.wr_data);
                    if (m_q.size() == N) m_pending = 1;
                end
            end else if (do_commit) begin
                for (int k = 0; k < N; k++) m_active[k] = m_q[k];
                m_q.delete();
                m_pending = 0;
            end
            if (sample_tick && !fwd) m_overrun = 1;
            else if (overrun_clr)    m_overrun = 0;
            if (m_tick)        m_running = 1;
            else if (fir_done) m_running = 0;
            m_tick = fwd;
            m_swapped = do_commit;
        end
    end

    bit cmp_en = 0;
    logic [N-1:0][W-1:0] run_bank;

    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            chk("fir_tick", {23'd0, fir_tick}, {23'd0, m_tick});
            chk("swapped", {23'd0, swapped}, {23'd0, m_swapped});
            chk("pending", {23'd0, pending}, {23'd0, m_pending});
            chk("overrun", {23'd0, overrun}, {23'd0, m_overrun});
            chk("wr_ready", {23'd0, wr_if.wr_ready}, {23'd0, !m_pending});
            for (int k = 0; k < N; k++)
                chk($sformatf("coeff[%0d]", k), coeff[k], m_active[k]);
            // Bank seen at the tick must still be in place when done arrives.
            if (fir_tick) run_bank = coeff;
            if (fir_done)
                for (int k = 0; k < N; k++)
                    chk($sformatf("run_stable[%0d]", k), coeff[k], run_bank[k]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            wr_if.wr_valid = 1'b1;
            wr_if.wr_data  = base + W'(k);
            step();
        end
        wr_if.wr_valid = 1'b0;
    endtask

    initial begin
        wr_if.wr_valid   = 1'b0;
        wr_if.wr_data    = '0;
        wr_if.load_abort = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cmp_en = 1;

        // Reset state and identity bank.
        @(negedge clk);
        chk("rst_coeff0", coeff[0], 24'h7FFFFF);
        chk("rst_coeff5", coeff[5], 24'h000000);
        chk("rst_ready", {23'd0, wr_if.wr_ready}, 24'd1);
        chk("rst_pending", {23'd0, pending}, 24'd0);

        // Tick with no load: forwarded one cycle later.
        step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        @(negedge clk);
        chk("tick_latency", {23'd0, fir_tick}, 24'd1);
        repeat (30) step();

        // Idle load of 0x100..0x116.
        load(24'h000100, N);
        @(negedge clk);
        chk("load_pending", {23'd0, pending}, 24'd1);
        chk("load_ready", {23'd0, wr_if.wr_ready}, 24'd0);
        chk("pre_swap_coeff0", coeff[0], 24'h7FFFFF);
        step();
        @(negedge clk);
        chk("swap_pulse", {23'd0, swapped}, 24'd1);
        chk("swap_coeff0", coeff[0], 24'h000100);
        chk("swap_coeff22", coeff[22], 24'h000116);

        // Load completing mid-run: commit waits for done.
        step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        load(24'h000200, N);
        @(negedge clk);
        chk("midrun_pending", {23'd0, pending}, 24'd1);
        chk("midrun_old_bank", coeff[0], 24'h000100);
        repeat (5) step();
        chk("midrun_new_bank", coeff[3], 24'h000203);
        repeat (30) step();

        // Overrun: second tick 5 cycles into a run.
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        repeat (4) step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        @(negedge clk);
        chk("overrun_no_tick", {23'd0, fir_tick}, 24'd0);
        chk("overrun_set", {23'd0, overrun}, 24'd1);
        step();
        sample_tick = 1'b1;
        overrun_clr = 1'b1;
        step();
        sample_tick = 1'b0;
        overrun_clr = 1'b0;
        @(negedge clk);
        chk("overrun_clr_loses", {23'd0, overrun}, 24'd1);
        step();
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        @(negedge clk);
        chk("overrun_cleared", {23'd0, overrun}, 24'd0);
        repeat (30) step();

        // Partial load, abort with a dropped write, then full load.
        load(24'h000300, 10);
        wr_if.wr_valid   = 1'b1;
        wr_if.wr_data    = 24'h00DEAD;
        wr_if.load_abort = 1'b1;
        step();
        wr_if.load_abort = 1'b0;
        wr_if.wr_valid   = 1'b0;
        load(24'h000400, N);
        step();
        @(negedge clk);
        chk("abort_coeff0", coeff[0], 24'h000400);
        chk("abort_coeff9", coeff[9], 24'h000409);
        chk("abort_coeff22", coeff[22], 24'h000416);

        // Reset mid-run with a pending bank and a sticky overrun.
        step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        load(24'h000500, N);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tick", {23'd0, fir_tick}, 24'd0);
        chk("arst_pending", {23'd0, pending}, 24'd0);
        chk("arst_overrun", {23'd0, overrun}, 24'd0);
        chk("arst_ready", {23'd0, wr_if.wr_ready}, 24'd1);
        chk("arst_coeff0", coeff[0], 24'h7FFFFF);
        chk("arst_coeff1", coeff[1], 24'h000000);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
